// File: rtl/axis_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_source
// Purpose  : AXI4-Stream video test-frame source. Emits raster-ordered frames
//            of IMG_W x IMG_H pixels with tuser on the first pixel and tlast
//            on the last one, honouring tready backpressure. Four pixel
//            patterns (constant, index, coordinates, LFSR) and an optional
//            frame count.
// Ports    : Clock, Rst_n (sync, active-low)
//            start/stop     - run control pulses
//            mode/const_val/num_frames - run configuration, latched on start
//            m_axis_*       - AXI4-Stream master (tvalid/tdata/tstrb/tlast/
//                             tuser out, tready in)
//            busy           - high while a run is in progress (RUN or GAP)
//            frame_done     - pulse the cycle after each tlast handshake
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_source #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    Clock,
  input  logic                    Rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   const_val,
  input  logic [7:0]              num_frames,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [15:0] c_X_LAST    = 16'(IMG_W - 1);
  localparam logic [15:0] c_Y_LAST    = 16'(IMG_H - 1);
  localparam int          c_GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST =
      c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] c_LFSR_SEED = 32'hACE1_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0]            r_x;
  logic [15:0]            r_y;
  logic [DATA_WIDTH-1:0]  r_idx;
  logic [31:0]            r_lfsr;
  logic [7:0]             r_frame_cnt;
  logic [c_GAP_W-1:0]     r_gap_cnt;
  logic                   r_stop_pend;
  logic                   r_frame_done;
  logic [1:0]             r_mode;
  logic [DATA_WIDTH-1:0]  r_const;
  logic [7:0]             r_num_frames;

  logic                   w_valid;
  logic                   w_hs;
  logic                   w_last_beat;
  logic                   w_frame_end;
  logic                   w_stop_now;
  logic                   w_count_done;
  logic                   w_gap_end;
  logic [31:0]            w_lfsr_step;
  logic [31:0]            w_coord;
  logic [DATA_WIDTH-1:0]  w_pixel;

  assign w_valid      = (r_state == RUN);
  assign w_hs         = w_valid & m_axis_tready;
  assign w_last_beat  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
  assign w_frame_end  = w_hs & w_last_beat;
  // A stop arriving on the very edge of the decision counts as pending.
  assign w_stop_now   = r_stop_pend | stop;
  assign w_count_done = (r_num_frames != 8'd0) && ((r_frame_cnt + 8'd1) == r_num_frames);
  assign w_gap_end    = (r_state == GAP) && (r_gap_cnt == c_GAP_LAST);

  // Galois form: shift right, fold the taps in when a one falls out.
  assign w_lfsr_step  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'h0);
  assign w_coord      = {r_y, r_x};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clock) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        if (w_frame_end) begin
          if (w_stop_now || w_count_done) w_state_nxt = IDLE;
          else if (GAP_CYCLES > 0)        w_state_nxt = GAP;
          else                            w_state_nxt = RUN;
        end
      end
      GAP: if (w_gap_end) w_state_nxt = w_stop_now ? IDLE : RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_idx        <= '0;
      r_lfsr       <= '0;
      r_frame_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_stop_pend  <= 1'b0;
      r_frame_done <= 1'b0;
      r_mode       <= '0;
      r_const      <= '0;
      r_num_frames <= '0;
    end else begin
      r_frame_done <= w_frame_end;

      if (w_state_nxt == IDLE)             r_stop_pend <= 1'b0;
      else if ((r_state != IDLE) && stop)  r_stop_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode       <= mode;
            r_const      <= const_val;
            r_num_frames <= num_frames;
            r_frame_cnt  <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_idx        <= '0;
            r_lfsr       <= c_LFSR_SEED;
          end
        end
        RUN: begin
          if (w_hs) begin
            if (w_last_beat) begin
              // Rewind for the next frame; every frame restarts the LFSR.
              r_x         <= '0;
              r_y         <= '0;
              r_idx       <= '0;
              r_lfsr      <= c_LFSR_SEED;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_gap_cnt   <= '0;
            end else begin
              if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 16'd1;
              end else begin
                r_x <= r_x + 16'd1;
              end
              r_idx  <= r_idx + DATA_WIDTH'(1);
              r_lfsr <= w_lfsr_step;
            end
          end
        end
        GAP: r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ outputs
  // r_idx tracks y*IMG_W + x without a multiplier.
  always_comb begin
    w_pixel = r_const;
    case (r_mode)
      2'd0:    w_pixel = r_const;
      2'd1:    w_pixel = r_idx;
      2'd2:    w_pixel = w_coord[DATA_WIDTH-1:0];
      default: w_pixel = r_lfsr[DATA_WIDTH-1:0];
    endcase
  end

  // Payload is forced to zero whenever tvalid is low.
  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? w_pixel : '0;
  assign m_axis_tstrb  = {(DATA_WIDTH/8){w_valid}};
  assign m_axis_tlast  = w_valid & w_last_beat;
  assign m_axis_tuser  = w_valid && (r_x == 16'd0) && (r_y == 16'd0);
  assign busy          = (r_state != IDLE);
  assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: doc/axis_frame_source.md
# axis_frame_source

AXI4-Stream video frame transmitter: generates raster-ordered test frames of IMG_W x IMG_H pixels as the stream source that feeds the image_process slave port. It marks start-of-frame on tuser and end-of-frame on tlast, obeys tready backpressure, and supports four selectable pixel patterns with an optional frame count. Used as the pixel source in block simulation and as an on-chip pattern source for bring-up.

## Interface
- DATA_WIDTH, 32, tdata width; legal range 16..32
- IMG_W, 640, pixels per line; legal range 2..65535
- IMG_H, 480, lines per frame; legal range 1..65535
- GAP_CYCLES, 2, tvalid-low cycles between consecutive frames; 0 is legal
- Clock  in  1  clock; all logic is rising-edge
- Rst_n  in  1  reset; synchronous, active-low
- start  in  1  single-cycle start request; ignored while busy=1
- stop  in  1  single-cycle request to finish the current frame, then return to IDLE
- mode  in  2  pattern select: 0 constant, 1 pixel index, 2 coordinates, 3 LFSR
- const_val  in  DATA_WIDTH  pixel value for mode 0
- num_frames  in  8  number of frames to send; 0 means continuous
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tdata  out  DATA_WIDTH  pixel
- m_axis_tstrb  out  DATA_WIDTH/8  all ones whenever tvalid=1, else 0
- m_axis_tlast  out  1  last pixel of frame
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tready  in  1  AXIS ready
- busy  out  1  high in RUN and GAP
- frame_done  out  1  one-cycle pulse, the cycle after the tlast beat is accepted

## Operation
- FSM states: IDLE, RUN, GAP.
- IDLE -> RUN: on start=1. mode, const_val and num_frames are latched on the same edge. Changes to these inputs during a run have no effect.
- RUN:
  - Beats are generated with counters x (0..IMG_W-1) and y (0..IMG_H-1), with x advancing first.
  - Counters advance only on a handshake (tvalid & tready).
- When the tlast beat is accepted:
  - frame_cnt increments.
  - If a stop is pending, or num_frames != 0 and frame_cnt reaches num_frames: go to IDLE.
  - Otherwise, if GAP_CYCLES > 0: go to GAP. If GAP_CYCLES = 0: stay in RUN, and the next frame's first beat is presented on the next cycle.
- GAP: tvalid=0 for exactly GAP_CYCLES cycles, then RUN. A stop arriving during GAP goes to IDLE when GAP ends.
- stop is latched into a pending flag whenever busy=1 and is cleared on entry to IDLE. stop while IDLE is ignored.
- Patterns (tdata truncated or zero-extended to DATA_WIDTH):
  - mode 0: const_val.
  - mode 1: y*IMG_W + x, modulo 2^DATA_WIDTH.
  - mode 2: {y[15:0], x[15:0]}.
  - mode 3: low DATA_WIDTH bits of a 32-bit Galois LFSR, taps 0x80200003.
    - The LFSR is seeded with 0xACE10001 at the start of every frame.
    - It steps once per accepted beat.
- tuser=1 only when x=0, y=0. tlast=1 only when x=IMG_W-1, y=IMG_H-1.
- IMG_H=1 and IMG_W=2 are legal: the frame is a single 2-beat line.

## Timing
- Reset values: tvalid=0, tdata=0, tstrb=0, tlast=0, tuser=0, busy=0, frame_done=0. All counters, frame_cnt, the LFSR and the pending stop are cleared; state is IDLE.
- Reset asserted mid-frame: all outputs take their reset values on the next edge. The partial frame is abandoned with no tlast.
- Latency: start sampled at edge N gives tvalid=1 with the first pixel (tuser=1) after edge N, i.e. during cycle N+1. busy=1 from the same edge.
- AXIS rules: once tvalid=1, tdata, tlast, tuser and tstrb are held stable until tready=1. tvalid never drops without a handshake, except on reset.
- Throughput: one beat per cycle with tready held high. A frame with tready=1 takes IMG_W*IMG_H cycles, plus GAP_CYCLES between frames.
- frame_done pulses on the cycle after the tlast handshake, including the final frame. busy falls on that same edge when going to IDLE.
- start on the same edge as the final tlast handshake is ignored (busy=1 at that time).
- stop and the tlast handshake on the same edge: the current frame counts as finished, and the block goes to IDLE immediately.

## Test plan
- **Constant pattern, no backpressure.** IMG_W=4, IMG_H=2, mode 0, const_val=3000, num_frames=1, tready=1.
  - 8 beats, all tdata=3000.
  - tuser on beat 0, tlast on beat 7.
  - frame_done one cycle later; busy=0 after.
- **Index pattern under backpressure.** mode 1, tready toggling 1,0,0,1,...
  - Accepted sequence is 0..7.
  - tdata is stable during every stall; no beat is lost or duplicated.
- **Coordinate pattern, multiple frames.** mode 2, num_frames=2, GAP_CYCLES=2.
  - Beats 0x00000000..0x00000003, then 0x00010000..0x00010003.
  - tvalid low for exactly 2 cycles between frames.
  - The second frame repeats the sequence; frame_done pulses twice.
- **LFSR pattern, continuous with stop.** mode 3, num_frames=0, stop pulsed mid-frame 3.
  - Frame 1 beat 0 is 0xACE10001; each frame repeats the identical sequence.
  - After stop, frame 3 completes with tlast, then the block returns to IDLE.
- **Reset and start rules.**
  - Rst_n=0 at beat 5: all outputs are 0 on the next edge.
  - A later start restarts at x=y=0 with tuser=1.
  - A start pulsed while busy has no effect on beat count.
- **Back-to-back frames with no gap.** GAP_CYCLES=0, num_frames=3, tready=1.
  - 24 consecutive valid beats with tlast then tuser on adjacent cycles.
